// File: rtl/dut_top_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dut_top_pkg                                                |
// | Description : Shared widths and beat types for the dut_top pass-through. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package dut_top_pkg;

  localparam int DW_DEF    = 8;
  localparam int CNT_W_DEF = 16;
  localparam int MAX_LAT   = 16;

  typedef logic [DW_DEF-1:0] byte_t;

  typedef struct packed {
    logic  dv;
    byte_t d;
  } beat_t;

endpackage
`default_nettype wire

// File: rtl/dut_delay_line.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dut_delay_line                                             |
// | Description : DEPTH-stage shift register with synchronous reset.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module dut_delay_line #(
  parameter int W     = 9,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] r_stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign dout = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/dut_top_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dut_top_core                                               |
// | Description : Byte-stream pass-through with frame/byte counters.         |
// |               DUT_FRAME_SUM_EN adds frame_sum/sum_vld outputs.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module dut_top_core
  import dut_top_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int LATENCY = 1,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    rxd,
  input  logic             rx_dv,
  output logic [DW-1:0]    txd,
  output logic             tx_en,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] byte_cnt,
  output logic             busy
`ifdef DUT_FRAME_SUM_EN
  ,
  output logic [DW-1:0]    frame_sum,
  output logic             sum_vld
`endif
);

  localparam int c_busy_w = $clog2(MAX_LAT + 2);
  // A sampled byte occupies the pipe for LATENCY cycles plus the cycle it is on the output.
  localparam logic [c_busy_w-1:0] c_busy_load = c_busy_w'(LATENCY + 1);

  logic [DW:0]          w_pipe_out;
  logic                 w_frame_end;
  logic                 r_dv_prev;
  logic [CNT_W-1:0]     r_frame_cnt;
  logic [CNT_W-1:0]     r_byte_cnt;
  logic [c_busy_w-1:0]  r_busy_cnt;

  dut_delay_line #(
    .W     (DW + 1),
    .DEPTH (LATENCY)
  ) u_pipe (
    .clk  (clk),
    .rst  (rst),
    .din  ({rx_dv, rxd}),
    .dout (w_pipe_out)
  );

  assign {tx_en, txd} = w_pipe_out;
  assign w_frame_end  = r_dv_prev & ~rx_dv;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dv_prev   <= 1'b0;
      r_frame_cnt <= '0;
      r_byte_cnt  <= '0;
      r_busy_cnt  <= '0;
    end else begin
      r_dv_prev <= rx_dv;
      if (rx_dv)       r_byte_cnt  <= r_byte_cnt + CNT_W'(1);
      if (w_frame_end) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      if (rx_dv)                  r_busy_cnt <= c_busy_load;
      else if (r_busy_cnt != '0)  r_busy_cnt <= r_busy_cnt - c_busy_w'(1);
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign byte_cnt  = r_byte_cnt;
  assign busy      = (r_busy_cnt != '0);

`ifdef DUT_FRAME_SUM_EN
  logic [DW-1:0] r_acc;
  logic [DW-1:0] r_frame_sum;
  logic          r_sum_vld;

  // Loading the first byte directly is the clear-at-frame-start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_frame_sum <= '0;
      r_sum_vld   <= 1'b0;
    end else begin
      r_sum_vld <= w_frame_end;
      if (w_frame_end) r_frame_sum <= r_acc;
      if (rx_dv)       r_acc <= r_dv_prev ? (r_acc + rxd) : rxd;
    end
  end

  assign frame_sum = r_frame_sum;
  assign sum_vld   = r_sum_vld;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dut_top_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_dut_top_core                                            |
// | Description : Self-checking bench, LATENCY=1 and LATENCY=4 instances.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_dut_top_core;
  import dut_top_pkg::*;

  logic  clk   = 1'b0;
  logic  rst   = 1'b1;
  logic  rx_dv = 1'b0;
  byte_t rxd   = '0;

  byte_t       txd1, txd4;
  logic        en1, en4, busy1, busy4;
  logic [15:0] fc1, fc4, bc1, bc4;
`ifdef DUT_FRAME_SUM_EN
  byte_t       fs1, fs4;
  logic        sv1, sv4;
`endif

  dut_top_core #(.DW(8), .LATENCY(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .rxd(rxd), .rx_dv(rx_dv), .txd(txd1), .tx_en(en1),
    .frame_cnt(fc1), .byte_cnt(bc1), .busy(busy1)
`ifdef DUT_FRAME_SUM_EN
    , .frame_sum(fs1), .sum_vld(sv1)
`endif
  );

  dut_top_core #(.DW(8), .LATENCY(4), .CNT_W(16)) u_dut4 (
    .clk(clk), .rst(rst), .rxd(rxd), .rx_dv(rx_dv), .txd(txd4), .tx_en(en4),
    .frame_cnt(fc4), .byte_cnt(bc4), .busy(busy4)
`ifdef DUT_FRAME_SUM_EN
    , .frame_sum(fs4), .sum_vld(sv4)
`endif
  );

  always #4 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: history of sampled beats (newest first) plus frame bookkeeping.
  logic [8:0]  hist[$];
  logic [15:0] m_fc, m_bc;
  logic        m_prev, m_vld;
  byte_t       m_acc, m_sum;

  typedef struct {
    logic        r;
    logic        dv;
    byte_t       d;
    logic        e_en;
    byte_t       e_txd;
    logic [15:0] e_fc;
    logic [15:0] e_bc;
    logic        e_busy;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    hist.delete();
    for (int i = 0; i <= MAX_LAT; i++) hist.push_back(9'h0);
    m_fc = '0; m_bc = '0; m_prev = 1'b0; m_vld = 1'b0; m_acc = '0; m_sum = '0;
  endtask

  task automatic model_update(input logic r, input logic dv, input byte_t d);
    if (r) begin
      model_clear();
    end else begin
      hist.push_front({dv, d});
      void'(hist.pop_back());
      m_vld = 1'b0;
      if (dv) begin
        m_bc++;
        m_acc = m_prev ? byte_t'(m_acc + d) : d;
      end else if (m_prev) begin
        m_fc++;
        m_sum = m_acc;
        m_vld = 1'b1;
      end
      m_prev = dv;
    end
  endtask

  function automatic logic m_busy(input int lat);
    for (int i = 0; i <= lat; i++) if (hist[i][8]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_model();
    chk("m1_tx_en", 32'(en1),   32'(hist[0][8]));
    chk("m1_txd",   32'(txd1),  32'(hist[0][7:0]));
    chk("m1_fcnt",  32'(fc1),   32'(m_fc));
    chk("m1_bcnt",  32'(bc1),   32'(m_bc));
    chk("m1_busy",  32'(busy1), 32'(m_busy(1)));
    chk("m4_tx_en", 32'(en4),   32'(hist[3][8]));
    chk("m4_txd",   32'(txd4),  32'(hist[3][7:0]));
    chk("m4_fcnt",  32'(fc4),   32'(m_fc));
    chk("m4_bcnt",  32'(bc4),   32'(m_bc));
    chk("m4_busy",  32'(busy4), 32'(m_busy(4)));
`ifdef DUT_FRAME_SUM_EN
    chk("m1_sum",   32'(fs1), 32'(m_sum));
    chk("m1_vld",   32'(sv1), 32'(m_vld));
    chk("m4_sum",   32'(fs4), 32'(m_sum));
    chk("m4_vld",   32'(sv4), 32'(m_vld));
`endif
  endtask

  task automatic step(input logic r, input logic dv, input byte_t d);
    rst = r; rx_dv = dv; rxd = d;
    @(posedge clk);
    model_update(r, dv, d);
    #1;
    check_model();
  endtask

  initial begin
    int en_cnt, busy_cnt, en_pos;
    byte_t en_data;

    model_clear();

    vt[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'd0, 16'd0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'd0, 16'd0, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'd0, 16'd0, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'd0, 16'd0, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 8'h11, 1'b1, 8'h11, 16'd0, 16'd1, 1'b1};
    vt[5]  = '{1'b0, 1'b1, 8'h22, 1'b1, 8'h22, 16'd0, 16'd2, 1'b1};
    vt[6]  = '{1'b0, 1'b1, 8'h33, 1'b1, 8'h33, 16'd0, 16'd3, 1'b1};
    vt[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'd1, 16'd3, 1'b1};
    vt[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'd1, 16'd3, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'd0, 16'd0, 1'b0};
    vt[10] = '{1'b0, 1'b1, 8'hAA, 1'b1, 8'hAA, 16'd0, 16'd1, 1'b1};
    vt[11] = '{1'b0, 1'b1, 8'hBB, 1'b1, 8'hBB, 16'd0, 16'd2, 1'b1};
    vt[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'd1, 16'd2, 1'b1};
    vt[13] = '{1'b0, 1'b1, 8'hCC, 1'b1, 8'hCC, 16'd1, 16'd3, 1'b1};
    vt[14] = '{1'b0, 1'b1, 8'hDD, 1'b1, 8'hDD, 16'd1, 16'd4, 1'b1};
    vt[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'd2, 16'd4, 1'b1};

    for (int i = 0; i < 16; i++) begin
      step(vt[i].r, vt[i].dv, vt[i].d);
      chk($sformatf("vec%0d_tx_en", i), 32'(en1),   32'(vt[i].e_en));
      chk($sformatf("vec%0d_txd", i),   32'(txd1),  32'(vt[i].e_txd));
      chk($sformatf("vec%0d_fcnt", i),  32'(fc1),   32'(vt[i].e_fc));
      chk($sformatf("vec%0d_bcnt", i),  32'(bc1),   32'(vt[i].e_bc));
      chk($sformatf("vec%0d_busy", i),  32'(busy1), 32'(vt[i].e_busy));
    end

    // Reset after byte 2 of a 4-byte frame: partial frame discarded, restart is a new frame.
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h01);
    step(1'b0, 1'b1, 8'h02);
    step(1'b1, 1'b1, 8'h03);
    chk("rstmid_tx_en", 32'(en1), 32'd0);
    chk("rstmid_fcnt",  32'(fc1), 32'd0);
    chk("rstmid_bcnt",  32'(bc1), 32'd0);
    step(1'b0, 1'b1, 8'h04);
    chk("rstmid_bcnt2", 32'(bc1), 32'd1);
    step(1'b0, 1'b0, 8'h00);
    chk("rstmid_fcnt2", 32'(fc1), 32'd1);

    // LATENCY=4 single byte: one tx_en pulse three edges after the sample edge, busy 5 cycles.
    step(1'b1, 1'b0, 8'h00);
    en_cnt = 0; busy_cnt = 0; en_pos = -1; en_data = '0;
    for (int k = 0; k < 9; k++) begin
      step(1'b0, (k == 0), (k == 0) ? 8'hA5 : 8'h00);
      if (en4) begin en_cnt++; en_pos = k; en_data = txd4; end
      if (busy4) busy_cnt++;
    end
    chk("lat4_en_count",   32'(en_cnt),   32'd1);
    chk("lat4_en_pos",     32'(en_pos),   32'd3);
    chk("lat4_en_data",    32'(en_data),  32'hA5);
    chk("lat4_busy_count", 32'(busy_cnt), 32'd5);

`ifdef DUT_FRAME_SUM_EN
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hF0);
    chk("sum_vld_mid", 32'(sv1), 32'd0);
    step(1'b0, 1'b1, 8'h20);
    step(1'b0, 1'b0, 8'h00);
    chk("sum_vld_end", 32'(sv1), 32'd1);
    chk("sum_value",   32'(fs1), 32'h10);
    chk("sum_fcnt",    32'(fc1), 32'd1);
    step(1'b0, 1'b0, 8'h00);
    chk("sum_vld_low", 32'(sv1), 32'd0);
    chk("sum_hold",    32'(fs1), 32'h10);
`endif

    // Randomized traffic with occasional reset, including reset coinciding with rx_dv.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 6), byte_t'($urandom));
    end
    for (int n = 0; n < 6; n++) step(1'b0, 1'b0, byte_t'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
